// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU cartridge bus master.
package nes_bus_pkg;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  localparam int unsigned HALF_CLKS_MIN = 2;
  localparam int unsigned CPU_ADDR_W    = 15;

endpackage

// File: rtl/nes_m2_phase_gen.sv
// Free-running M2 generator: LOW half then HIGH half, HALF_CLKS clks each, never stalls.
// Strobes: cycle_start (first LOW clk), high_last (last HIGH clk), m2_fall (clk after high_last).
module nes_m2_phase_gen
  import nes_bus_pkg::*;
#(
  parameter int unsigned HALF_CLKS = 6
) (
  input  logic clk,
  input  logic rst,
  output logic m2,
  output logic cycle_start,
  output logic high_last,
  output logic m2_fall
);

  localparam logic [7:0] LAST = 8'(HALF_CLKS - 1);

  if (HALF_CLKS < HALF_CLKS_MIN || HALF_CLKS > 255) begin : g_bad_half
    $error("HALF_CLKS out of range");
  end

  phase_t     phase, phase_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       half_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= PH_LOW;
      cnt     <= 8'd0;
      m2_fall <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      cnt     <= cnt_nxt;
      m2_fall <= high_last;
    end
  end

  always_comb begin
    half_end  = (cnt == LAST);
    phase_nxt = phase;
    cnt_nxt   = cnt + 8'd1;
    if (half_end) begin
      cnt_nxt = 8'd0;
      case (phase)
        PH_LOW:  phase_nxt = PH_HIGH;
        PH_HIGH: phase_nxt = PH_LOW;
        default: phase_nxt = PH_LOW;
      endcase
    end
  end

  assign m2          = (phase == PH_HIGH);
  assign cycle_start = (phase == PH_LOW) && (cnt == 8'd0);
  assign high_last   = (phase == PH_HIGH) && half_end;

endmodule

// File: rtl/nes_cpu_bus_master.sv
// NES CPU cartridge bus initiator: one-entry request register feeding continuous M2 cycles; optional IRQ sticky flag under NES_BUS_IRQ_EN.
// Response 2*HALF_CLKS clks after cycle start; req_ready drops while the single entry waits for the next cycle.
module nes_cpu_bus_master
  import nes_bus_pkg::*;
#(
  parameter int unsigned HALF_CLKS = 6,
  parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [15:0]           req_addr,
  input  logic [7:0]            req_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  m2,
  output logic [CPU_ADDR_W-1:0] cpu_addr,
  output logic                  romsel,
  output logic                  cpu_rw,
  output logic [7:0]            cpu_data_out,
  output logic                  cpu_data_oe,
  input  logic [7:0]            cpu_data_in,
  input  logic                  irq_n,
  output logic                  irq_flag,
  input  logic                  irq_clear,
  output logic [15:0]           m2_cycles
);

  localparam req_t IDLE_REQ = '{rw: 1'b1, addr: IDLE_ADDR, wdata: 8'h00};

  req_t hold_q, cyc_q;
  logic pending, cyc_req, last_req;
  logic cycle_start, high_last, m2_fall;
  logic accept;

  nes_m2_phase_gen #(.HALF_CLKS(HALF_CLKS)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .m2         (m2),
    .cycle_start(cycle_start),
    .high_last  (high_last),
    .m2_fall    (m2_fall)
  );

  assign req_ready = ~pending;
  assign accept    = req_valid & req_ready;

  // Cycle registers load on the edge closing the HIGH half, so address and
  // R/W are already stable on the first LOW clk and only change at M2 fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 1'b0;
      hold_q    <= IDLE_REQ;
      cyc_q     <= IDLE_REQ;
      cyc_req   <= 1'b0;
      last_req  <= 1'b0;
      rsp_rdata <= 8'h00;
      m2_cycles <= 16'd0;
    end else begin
      if (accept) hold_q <= '{rw: req_rw, addr: req_addr, wdata: req_wdata};
      pending <= (pending & ~high_last) | accept;
      if (high_last) begin
        cyc_q     <= pending ? hold_q : IDLE_REQ;
        cyc_req   <= pending;
        last_req  <= cyc_req;
        m2_cycles <= m2_cycles + 16'd1;
        if (cyc_req && cyc_q.rw) rsp_rdata <= cpu_data_in;
      end
    end
  end

  assign rsp_valid    = m2_fall & last_req;
  assign cpu_addr     = cyc_q.addr[CPU_ADDR_W-1:0];
  assign cpu_rw       = cyc_q.rw;
  assign romsel       = ~(m2 & cyc_q.addr[15]);
  assign cpu_data_oe  = m2 & ~cyc_q.rw;
  assign cpu_data_out = cpu_data_oe ? cyc_q.wdata : 8'h00;

`ifndef SYNTHESIS
  a_fall_is_start: assert property (@(posedge clk) disable iff (rst) m2_fall |-> cycle_start);
`endif

`ifdef NES_BUS_IRQ_EN
  logic irq_s1, irq_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_s1   <= 1'b1;
      irq_s2   <= 1'b1;
      irq_flag <= 1'b0;
    end else begin
      irq_s1 <= irq_n;
      irq_s2 <= irq_s1;
      if (!irq_s2)        irq_flag <= 1'b1;
      else if (irq_clear) irq_flag <= 1'b0;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = irq_n ^ irq_clear;
  assign irq_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// Directed bench for nes_cpu_bus_master (HALF_CLKS = 6, IDLE_ADDR = 0).
module tb_nes_cpu_bus_master;

  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2;
  logic [14:0] cpu_addr;
  logic        romsel, cpu_rw, cpu_data_oe;
  logic [7:0]  cpu_data_out, cpu_data_in;
  logic        irq_n, irq_flag, irq_clear;
  logic [15:0] m2_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nes_cpu_bus_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .m2(m2), .cpu_addr(cpu_addr), .romsel(romsel), .cpu_rw(cpu_rw),
    .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in),
    .irq_n(irq_n), .irq_flag(irq_flag), .irq_clear(irq_clear),
    .m2_cycles(m2_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    repeat (n) tick;
  endtask

  task automatic send(input logic rw, input logic [15:0] addr, input logic [7:0] wdata);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && n < 40) begin
      tick;
      n++;
    end
    check("send_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_m2"},       m2, 0);
    check({tag, "_romsel"},   romsel, 1);
    check({tag, "_rw"},       cpu_rw, 1);
    check({tag, "_addr"},     cpu_addr, 0);
    check({tag, "_oe"},       cpu_data_oe, 0);
    check({tag, "_dout"},     cpu_data_out, 0);
    check({tag, "_rspv"},     rsp_valid, 0);
    check({tag, "_rdata"},    rsp_rdata, 0);
    check({tag, "_ready"},    req_ready, 1);
    check({tag, "_irq"},      irq_flag, 0);
    check({tag, "_m2cycles"}, m2_cycles, 0);
  endtask

  // Starts on the first LOW clk of the cycle; returns on the M2-fall clk.
  task automatic observe(input string tag, input logic rw, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata);
    int bus_bad, oe_hi, rsp_bad;
    bus_bad = 0;
    oe_hi   = 0;
    rsp_bad = 0;
    for (int k = 0; k < 2 * H; k++) begin
      logic hi;
      hi = (k >= H);
      if (m2 !== hi || cpu_rw !== rw || cpu_addr !== addr[14:0]) bus_bad++;
      if (romsel !== (hi ? ~addr[15] : 1'b1)) bus_bad++;
      if (cpu_data_oe !== (hi & ~rw)) bus_bad++;
      if (hi && !rw && cpu_data_out !== wdata) bus_bad++;
      if (cpu_data_oe === 1'b1) oe_hi++;
      if (k > 0 && rsp_valid !== 1'b0) rsp_bad++;
      tick;
    end
    check({tag, "_bus"}, bus_bad, 0);
    check({tag, "_oe_clks"}, oe_hi, rw ? 0 : H);
    check({tag, "_early_rsp"}, rsp_bad, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    if (rw) check({tag, "_rdata"}, rsp_rdata, rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m2_bad, hi_cnt, misc_bad, rsp_cnt;
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b1; req_addr = 16'h0; req_wdata = 8'h0;
    cpu_data_in = 8'hFF; irq_n = 1'b1; irq_clear = 1'b0;

    skip(3);
    check_reset("rst");
    rst = 1'b0;
    check_reset("rel");

    // Idle run: 10 full M2 cycles.
    m2_bad = 0; hi_cnt = 0; misc_bad = 0; rsp_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      if (m2 !== ((i % (2 * H)) >= H)) m2_bad++;
      if (m2 === 1'b1) hi_cnt++;
      if (romsel !== 1'b1 || cpu_rw !== 1'b1 || cpu_data_oe !== 1'b0) misc_bad++;
      if (rsp_valid !== 1'b0) rsp_cnt++;
      tick;
    end
    check("idle_m2_shape", m2_bad, 0);
    check("idle_m2_high_clks", hi_cnt, 60);
    check("idle_bus_quiet", misc_bad, 0);
    check("idle_no_rsp", rsp_cnt, 0);
    check("idle_m2_cycles", m2_cycles, 10);

    send(1'b0, 16'h6000, 8'h85);
    skip(2 * H - 1);
    observe("wr6000", 1'b0, 16'h6000, 8'h85, 8'h00);

    cpu_data_in = 8'h5A;
    send(1'b1, 16'hC000, 8'h00);
    skip(2 * H - 1);
    observe("rdC000", 1'b1, 16'hC000, 8'h00, 8'h5A);
    cpu_data_in = 8'hFF;

    fork
      begin
        send(1'b0, 16'h6000, 8'h11);
        check("b2b_ready_low", req_ready, 0);
        send(1'b0, 16'h6001, 8'h22);
        send(1'b0, 16'h8000, 8'h33);
      end
      begin
        skip(2 * H);
        observe("b2b_w1", 1'b0, 16'h6000, 8'h11, 8'h00);
        observe("b2b_w2", 1'b0, 16'h6001, 8'h22, 8'h00);
        observe("b2b_w3", 1'b0, 16'h8000, 8'h33, 8'h00);
      end
    join
    check("rdata_hold", rsp_rdata, 8'h5A);
    check("m2_cycles_b2b", m2_cycles, 18);

    // Reset three clks into the HIGH half of a write.
    send(1'b0, 16'h6002, 8'h44);
    skip(2 * H - 1);
    skip(H + 3);
    check("pre_rst_oe", cpu_data_oe, 1);
    check("pre_rst_rw", cpu_rw, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_reset("midrst");
    misc_bad = 0; rsp_cnt = 0;
    for (int k = 0; k < 2 * H; k++) begin
      if (cpu_rw !== 1'b1 || cpu_addr !== 15'h0 || m2 !== (k >= H)) misc_bad++;
      if (rsp_valid !== 1'b0) rsp_cnt++;
      tick;
    end
    check("post_rst_idle", misc_bad, 0);
    check("post_rst_no_rsp", rsp_cnt, 0);
    check("post_rst_fall_rsp", rsp_valid, 0);
    check("post_rst_m2_cycles", m2_cycles, 1);

`ifdef NES_BUS_IRQ_EN
    begin
      int n;
      irq_n = 1'b0;
      tick;
      irq_n = 1'b1;
      n = 0;
      while (irq_flag !== 1'b1 && n < 3) begin
        tick;
        n++;
      end
      check("irq_set", irq_flag, 1);
      irq_clear = 1'b1;
      tick;
      irq_clear = 1'b0;
      check("irq_cleared", irq_flag, 0);
      irq_n = 1'b0;
      skip(3);
      irq_clear = 1'b1;
      tick;
      check("irq_set_wins", irq_flag, 1);
      irq_clear = 1'b0;
      irq_n = 1'b1;
      skip(3);
      irq_clear = 1'b1;
      tick;
      irq_clear = 1'b0;
      check("irq_cleared2", irq_flag, 0);
    end
`else
    irq_n = 1'b0;
    skip(5);
    check("irq_disabled", irq_flag, 0);
    irq_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nes_cpu_bus_master.md
# nes_cpu_bus_master

Synthesizable initiator for the NES CPU cartridge bus. It turns a simple valid/ready request stream into cycle-accurate M2 / ROMSEL / R/W / address / data sequences and returns read data. It sits opposite the cartridge mapper in the FPGA test harness and in the flash-programmer bridge. M2 runs continuously, with idle cycles when no request is pending, so mapper logic clocked on the M2 falling edge (register writes, IRQ timers) sees a real bus.

## Interface
- HALF_CLKS, 6: clk cycles per M2 half-period; legal range 2..255.
- IDLE_ADDR, 16'h0000: address presented on idle cycles.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  the holding register is empty.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  16  CPU address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-clk pulse at the end of every requested cycle, reads and writes.
- rsp_rdata  out  8  sampled read data; holds its value until the next read response.
- m2  out  1  CPU M2 clock.
- cpu_addr  out  15  A14..A0.
- romsel  out  1  /ROMSEL, active low.
- cpu_rw  out  1  R/W.
- cpu_data_out  out  8  write data.
- cpu_data_oe  out  1  data bus drive enable.
- cpu_data_in  in  8  data bus input.
- irq_n  in  1  cartridge /IRQ; open-drain, pulled up externally.
- irq_flag  out  1  sticky IRQ seen.
- irq_clear  in  1  clears irq_flag.
- m2_cycles  out  16  count of completed M2 cycles; wraps.

## Operation
- Holding register
  - One entry.
  - req_ready = !pending.
  - A handshake (req_valid & req_ready) loads the entry and sets pending.
- M2 cycle structure
  - Total length is 2*HALF_CLKS clks: a LOW half, then a HIGH half.
- Cycle start (first clk of LOW)
  - If pending: latch the entry into the cycle registers and clear pending.
  - A new request may be accepted in that same clk.
  - Otherwise: run an idle cycle with addr = IDLE_ADDR, rw = 1.
- LOW half
  - m2 = 0, romsel = 1.
  - cpu_addr and cpu_rw are valid from the first clk.
  - cpu_data_oe = 0.
- HIGH half
  - m2 = 1.
  - romsel = !addr[15].
  - Writes only: cpu_data_oe = 1 and cpu_data_out = wdata for the whole half.
- End of HIGH half (last clk)
  - Reads: sample cpu_data_in into rsp_rdata.
- Next clk (m2 falling)
  - rsp_valid = 1 for requested cycles only; never for idle cycles.
  - m2_cycles increments on every cycle, idle or requested.
- Address and R/W hold
  - cpu_addr and cpu_rw hold from cycle start until the next cycle start. No glitch at the M2 fall.
- States
  - LOW → HIGH when the phase count reaches HALF_CLKS-1.
  - HIGH → LOW when the phase count reaches HALF_CLKS-1.
  - There is no other state. The bus never stops.
- Back-to-back requests
  - A request accepted during cycle N issues in cycle N+1 with no idle cycle between.

## Timing
- Reset values (rst high, and the clk after it deasserts)
  - m2 = 0, romsel = 1, cpu_rw = 1, cpu_addr = IDLE_ADDR[14:0].
  - cpu_data_oe = 0, cpu_data_out = 0.
  - rsp_valid = 0, rsp_rdata = 0.
  - pending = 0, so req_ready = 1.
  - irq_flag = 0, m2_cycles = 0, phase = LOW with count 0.
- Reset mid-cycle
  - Aborts the cycle and drops any pending request.
  - No rsp_valid.
  - LOW restarts on the first clk after rst falls.
- Latency
  - If the request is accepted while the bus is idle, worst case is 2*HALF_CLKS clks to cycle start, then 2*HALF_CLKS clks to rsp_valid.
- Simultaneous events
  - irq_clear and a new IRQ detection in the same clk: the set wins.
  - Handshake in the same clk as a cycle-start load: both happen (the old entry is consumed, the new one is stored).

## Configuration
- NES_BUS_IRQ_EN defined
  - irq_n passes through a 2-flop synchronizer.
  - irq_flag sets on synchronized low and clears only on irq_clear.
  - Worst-case detect latency is 3 clks.
- NES_BUS_IRQ_EN undefined
  - irq_n is ignored.
  - irq_flag is tied to 0.
  - No synchronizer flops are instantiated.

## Structure
- Shared package nes_bus_pkg holds:
  - the phase enum (PH_LOW, PH_HIGH);
  - the request struct (rw, addr, wdata);
  - the constants HALF_CLKS_MIN = 2 and CPU_ADDR_W = 15.
- One sub-module, nes_m2_phase_gen.
  - Holds the phase counter and the m2 output.
  - Emits one-clk strobes: cycle_start, high_last, m2_fall.
- The top level holds the holding register, the cycle registers, response generation, the IRQ logic and m2_cycles.

## Test plan
- Idle run, no requests, HALF_CLKS = 6 → m2 period is 12 clks with exactly 6 clks high; romsel stays 1; cpu_rw stays 1; rsp_valid never asserts; m2_cycles = 10 after 120 clks.
- Write $6000 ← 8'h85 → cpu_rw = 0 for the whole cycle; romsel stays 1 throughout; cpu_data_oe = 1 only while m2 = 1; rsp_valid pulses on the clk m2 falls.
- Read $C000 with cpu_data_in = 8'h5A → romsel = 0 exactly while m2 = 1; rsp_rdata = 8'h5A with rsp_valid.
- Three back-to-back writes ($6000, $6001, $8000) → three consecutive M2 cycles with no idle between; req_ready deasserts while an entry is pending.
- rst asserted 3 clks into the HIGH half of a write → the next clk shows all reset values; no rsp_valid; the following cycle is idle.
- With NES_BUS_IRQ_EN: irq_n low for 1 clk → irq_flag = 1 within 3 clks; irq_clear clears it. Without the macro, irq_flag stays 0.
